// File: rtl/memory_arbiter_rr.sv
// memory_arbiter_rr: round-robin arbiter that folds the instruction and data
// channels of CPUS caches onto one RAM port. Requester 2k is the data channel
// of CPU k, requester 2k+1 its instruction channel. A grant is chosen in IDLE,
// held in OWN until RAM reports completion or the owner withdraws, and the
// round-robin pointer only advances past a requester that actually completed.
//
// Optional feature: define MEMARB_DPRIO_EN to give data channels strict
// priority over instruction channels during arbitration.
module memory_arbiter_rr #(
    parameter int         CPUS       = 2,
    parameter int         WORD_W     = 32,
    parameter logic [1:0] RAM_ACCESS = 2'b10
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [CPUS-1:0]          iREN,
    input  logic [CPUS*WORD_W-1:0]   iaddr,
    input  logic [CPUS-1:0]          dREN,
    input  logic [CPUS-1:0]          dWEN,
    input  logic [CPUS*WORD_W-1:0]   daddr,
    input  logic [CPUS*WORD_W-1:0]   dstore,
    output logic [CPUS-1:0]          iwait,
    output logic [CPUS-1:0]          dwait,
    output logic [CPUS*WORD_W-1:0]   iload,
    output logic [CPUS*WORD_W-1:0]   dload,
    output logic                     ramREN,
    output logic                     ramWEN,
    output logic [WORD_W-1:0]        ramaddr,
    output logic [WORD_W-1:0]        ramstore,
    input  logic [WORD_W-1:0]        ramload,
    input  logic [1:0]               ramstate
);

    localparam int N     = 2 * CPUS;
    localparam int IDX_W = $clog2(N);

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] g, g_next;
    logic [IDX_W-1:0] ptr, ptr_next;
    logic [IDX_W-1:0] pick;
    logic [N-1:0]     req;
    logic [N-1:0]     search_req;
    logic [CPUS-1:0]  data_req;
    logic             owner_active;
    logic             done;

    // (base + off) mod N for base < N and 0 <= off < N; N need not be a power of two.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N) s = s - N;
        return IDX_W'(s);
    endfunction

    // Flatten the per-CPU request lines into the requester vector; a data
    // channel requests on either read or write.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves a signal unassigned and no latch is inferred.
        req      = '0;
        data_req = dREN | dWEN;
        for (int k = 0; k < CPUS; k++) begin
            req[2*k]   = data_req[k];
            req[2*k+1] = iREN[k];
        end
    end

    // Candidate set for arbitration (data-only when data priority applies).
    always_comb begin
        search_req = req;
`ifdef MEMARB_DPRIO_EN
        if (|data_req) begin
            for (int k = 0; k < CPUS; k++) search_req[2*k+1] = 1'b0;
        end
`endif
    end

    // Round-robin pick: first candidate at ptr, ptr+1, ... (mod N). Scanning
    // from the far end means the nearest candidate is the one that sticks.
    always_comb begin
        pick = ptr;
        for (int i = N - 1; i >= 0; i--) begin
            if (search_req[wrap_add(ptr, i)]) pick = wrap_add(ptr, i);
        end
    end

    assign owner_active = (state == OWN) && req[g];
    assign done         = owner_active && (ramstate == RAM_ACCESS);

    // Next-state logic: arbitrate in IDLE, hold the grant in OWN until
    // completion (advance pointer) or withdrawal (pointer untouched).
    always_comb begin
        state_next = state;
        g_next     = g;
        ptr_next   = ptr;
        case (state)
            IDLE: begin
                if (|req) begin
                    g_next     = pick;
                    state_next = OWN;
                end
            end
            OWN: begin
                if (!req[g]) begin
                    state_next = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    ptr_next   = wrap_add(g, 1);
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, grant and pointer registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            g     <= '0;
            ptr   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state <= state_next;
            g     <= g_next;
            ptr   <= ptr_next;
        end
    end

    // RAM drive and wait lines follow the owner's live inputs; because they
    // decode the registered state, an asynchronous reset drops them at once.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = '1;
        dwait    = '1;
        if (owner_active) begin
            for (int k = 0; k < CPUS; k++) begin
                if (g == IDX_W'(2*k)) begin
                    ramaddr = daddr[k*WORD_W +: WORD_W];
                    if (dWEN[k]) begin
                        ramWEN   = 1'b1;
                        ramstore = dstore[k*WORD_W +: WORD_W];
                    end else begin
                        ramREN = 1'b1;
                    end
                    dwait[k] = !done;
                end
                if (g == IDX_W'(2*k+1)) begin
                    ramREN   = 1'b1;
                    ramaddr  = iaddr[k*WORD_W +: WORD_W];
                    iwait[k] = !done;
                end
            end
        end
    end

    // Read data is broadcast; each cache qualifies it with its own wait line.
    assign iload = {CPUS{ramload}};
    assign dload = {CPUS{ramload}};

endmodule

// File: tb/tb_memory_arbiter_rr.sv
// Testbench for memory_arbiter_rr (CPUS=2). A transaction-level model keeps
// only "who owns the port" and the round-robin pointer, predicts the bus on
// every cycle, and directed scenarios add hand-computed literal expectations.
// Build with MEMARB_DPRIO_EN defined to exercise the data-priority variant.
module tb_memory_arbiter_rr;

    localparam int         CPUS   = 2;
    localparam int         WORD_W = 32;
    localparam int         N      = 2 * CPUS;
    localparam logic [1:0] FREE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] ACC    = 2'b10;

    logic                   CLK;
    logic                   nRST;
    logic [CPUS-1:0]        iREN, dREN, dWEN;
    logic [CPUS*WORD_W-1:0] iaddr, daddr, dstore;
    logic [CPUS-1:0]        iwait, dwait;
    logic [CPUS*WORD_W-1:0] iload, dload;
    logic                   ramREN, ramWEN;
    logic [WORD_W-1:0]      ramaddr, ramstore, ramload;
    logic [1:0]             ramstate;

    int vectors = 0;
    int fails   = 0;
    int grants[$];
    int exp3[5];
    int exp6[4];

    // Model state: owner index (-1 = nobody) and round-robin start point.
    int m_owner = -1;
    int m_ptr   = 0;

    memory_arbiter_rr #(
        .CPUS(CPUS), .WORD_W(WORD_W), .RAM_ACCESS(ACC)
    ) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit req_of(input int c);
        if (c % 2 == 0) return dREN[c/2] | dWEN[c/2];
        return iREN[c/2];
    endfunction

    // Who would win arbitration right now, or -1 if nobody asks.
    function automatic int model_pick();
        bit any_data = 1'b0;
        for (int k = 0; k < CPUS; k++) any_data |= dREN[k] | dWEN[k];
        for (int i = 0; i < N; i++) begin
            int c = (m_ptr + i) % N;
            bit eligible = req_of(c);
`ifdef MEMARB_DPRIO_EN
            if (any_data && (c % 2 == 1)) eligible = 1'b0;
`endif
            if (eligible) return c;
        end
        return -1;
    endfunction

    // Expected {ramREN, ramWEN, ramaddr, ramstore, iwait, dwait}.
    function automatic logic [69:0] model_bus();
        logic        ren = 1'b0, wen = 1'b0;
        logic [31:0] addr = '0, store = '0;
        logic [1:0]  iw = 2'b11, dw = 2'b11;
        if (m_owner >= 0 && req_of(m_owner)) begin
            int cpu = m_owner / 2;
            if (m_owner % 2 == 0) begin
                addr = daddr[cpu*WORD_W +: WORD_W];
                if (dWEN[cpu]) begin
                    wen   = 1'b1;
                    store = dstore[cpu*WORD_W +: WORD_W];
                end else begin
                    ren = 1'b1;
                end
                if (ramstate == ACC) dw[cpu] = 1'b0;
            end else begin
                ren  = 1'b1;
                addr = iaddr[cpu*WORD_W +: WORD_W];
                if (ramstate == ACC) iw[cpu] = 1'b0;
            end
        end
        return {ren, wen, addr, store, iw, dw};
    endfunction

    // Model update: a transfer ends on completion (pointer moves past the
    // owner) or withdrawal (pointer kept); a new owner is chosen only when idle.
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_owner <= -1;
            m_ptr   <= 0;
        end else if (m_owner < 0) begin
            if (model_pick() >= 0) m_owner <= model_pick();
        end else if (!req_of(m_owner)) begin
            m_owner <= -1;
        end else if (ramstate == ACC) begin
            m_ptr   <= (m_owner + 1) % N;
            m_owner <= -1;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge CLK) begin
        check("bus", {ramREN, ramWEN, ramaddr, ramstore, iwait, dwait}, model_bus());
        check("loads", {iload, dload}, {(2*CPUS){ramload}});
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Record the channel of each transfer (address encodes the channel).
    task automatic collect(input int want);
        grants.delete();
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (ramREN || ramWEN) grants.push_back(int'((ramaddr - 32'h1000) >> 8));
            if (grants.size() >= want) break;
        end
        check("grant_count", grants.size(), want);
    endtask

    initial begin
`ifdef MEMARB_DPRIO_EN
        exp3 = '{0, 2, 0, 2, 0};
        exp6 = '{2, 2, 2, 2};
`else
        exp3 = '{0, 1, 2, 3, 0};
        exp6 = '{1, 2, 1, 2};
`endif
        nRST = 1'b0; iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramload = 32'hA5A5_0001; ramstate = FREE;
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;

        // Reset state.
        @(negedge CLK);
        check("rst_en", {ramREN, ramWEN}, 2'b00);
        check("rst_waits", {iwait, dwait}, 4'hF);
        check("rst_addr", ramaddr, 32'h0);
        check("rst_store", ramstore, 32'h0);

        // Instruction read by CPU0, completion on the second OWN cycle.
        cyc(); iREN[0] = 1'b1; iaddr[31:0] = 32'h100; ramstate = BUSY; ramload = 32'hCAFE_0100;
        @(negedge CLK); check("t1_arb_idle", ramREN, 1'b0);
        cyc();
        @(negedge CLK);
        check("t1_ren", ramREN, 1'b1);
        check("t1_addr", ramaddr, 32'h100);
        check("t1_iwait_busy", iwait, 2'b11);
        cyc(); ramstate = ACC;
        @(negedge CLK);
        check("t1_iwait_done", iwait, 2'b10);
        check("t1_iload", iload[31:0], 32'hCAFE_0100);
        cyc(); iREN = '0; ramstate = FREE;
        @(negedge CLK); check("t1_back_idle", ramREN, 1'b0);

        // CPU1 data read granted (g=2), then withdrawn before ACCESS.
        cyc(); dREN[1] = 1'b1; daddr[63:32] = 32'h200; ramstate = BUSY;
        cyc();
        @(negedge CLK);
        check("t4_ren", ramREN, 1'b1);
        check("t4_addr", ramaddr, 32'h200);
        cyc(); dREN[1] = 1'b0;
        @(negedge CLK);
        check("t4_abort_en", {ramREN, ramWEN}, 2'b00);
        check("t4_abort_dwait", dwait, 2'b11);
        // Pointer still 2: with d0 and d1 both asking, d1 must win.
        cyc(); dREN = 2'b11; daddr[31:0] = 32'h300; ramstate = ACC;
        cyc();
        @(negedge CLK);
        check("t4_ptr_kept", ramaddr, 32'h200);
        check("t4_dwait", dwait, 2'b01);
        cyc(); dREN = '0; ramstate = FREE;

        // CPU0 write with read also set: write wins.
        cyc(); dWEN[0] = 1'b1; dREN[0] = 1'b1; daddr[31:0] = 32'h40;
        dstore[31:0] = 32'hDEAD_BEEF; ramstate = ACC;
        cyc();
        @(negedge CLK);
        check("t2_en", {ramREN, ramWEN}, 2'b01);
        check("t2_store", ramstore, 32'hDEAD_BEEF);
        check("t2_addr", ramaddr, 32'h40);
        check("t2_dwait", dwait, 2'b10);
        cyc(); dWEN = '0; dREN = '0; ramstate = FREE;

        // Reset asserted in the middle of a write.
        cyc(); dWEN[0] = 1'b1; daddr[31:0] = 32'h80; dstore[31:0] = 32'h1234_5678; ramstate = BUSY;
        cyc();
        @(negedge CLK); check("t5_wen", ramWEN, 1'b1);
        #2 nRST = 1'b0;
        #1;
        check("t5_async_wen", {ramREN, ramWEN}, 2'b00);
        check("t5_async_waits", {iwait, dwait}, 4'hF);
        check("t5_async_addr", ramaddr, 32'h0);
        cyc(); dWEN = '0; dstore = '0; ramstate = ACC;
        daddr = {32'h1200, 32'h1000}; iaddr = {32'h1300, 32'h1100}; ramload = 32'h5A5A_0003;
        @(negedge CLK); #2 nRST = 1'b1;

        // All four channels requesting, ACCESS always: order from index 0.
        cyc(); dREN = 2'b11; iREN = 2'b11;
        collect(5);
        for (int i = 0; i < 5 && i < grants.size(); i++)
            check($sformatf("t3_grant%0d", i), grants[i], exp3[i]);

        // i0 and d1 held together.
        cyc(); dREN = 2'b10; iREN = 2'b01;
        collect(4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            check($sformatf("t6_grant%0d", i), grants[i], exp6[i]);

        cyc(); dREN = '0; iREN = '0; ramstate = FREE;
        repeat (3) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
